ahb_dma_cfg_master: RTL and testbench

//  AHB-Lite initiator that programs the DMA configuration register bank over AHB for a local requester.
//  Per accepted command it performs four single writes: source address, destination address, beat count, start=1.
//  It then polls the start register until the DMA clears it, and reports done or error.

---
 rtl/ahb_dma_cfg_master_if.sv | 30 +++
 rtl/ahb_dma_cfg_master.sv | 197 +++++++++++++++++++
 tb/tb_ahb_dma_cfg_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_dma_cfg_master_if.sv
// Command handshake and AHB-Lite initiator signals of the DMA configuration master.
// Handshake: a command transfers on a rising hclk edge where cmd_valid && cmd_ready.
interface ahb_dma_cfg_master_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_saddr;
    logic [31:0] cmd_daddr;
    logic [13:0] cmd_number;
    logic        busy;
    logic        done_pulse;
    logic        err_pulse;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  cmd_valid, cmd_saddr, cmd_daddr, cmd_number, hrdata, hready, hresp,
        output cmd_ready, busy, done_pulse, err_pulse, haddr, htrans, hwrite, hsize, hwdata
    );

    modport slave (
        output cmd_valid, cmd_saddr, cmd_daddr, cmd_number, hrdata, hready, hresp,
        input  cmd_ready, busy, done_pulse, err_pulse, haddr, htrans, hwrite, hsize, hwdata
    );
endinterface

// File: rtl/ahb_dma_cfg_master.sv
// Programs the DMA register bank with four AHB writes, then polls start until it clears.
// Optional poll timeout is enabled by defining DMA_CFG_POLL_TIMEOUT_EN.
module ahb_dma_cfg_master #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned POLL_GAP       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        hclk,
    input  logic                        hreset,
    ahb_dma_cfg_master_if.master        bus,
    output logic [3:0]                  o_dbg_state
);
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADDR  = 4'd1,
        S_DATA  = 4'd2,
        S_PADDR = 4'd3,
        S_PDATA = 4'd4,
        S_GAP   = 4'd5,
        S_DONE  = 4'd6,
        S_ERR   = 4'd7
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [7:0]  LP_GAP        = 8'(POLL_GAP);
    localparam logic [15:0] LP_TMO        = 16'(TIMEOUT_CYCLES);
    localparam logic [31:0] START_ADDR    = BASE_ADDR + 32'hC;

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_saddr;
    logic [31:0] r_daddr;
    logic [13:0] r_number;
    logic [7:0]  r_gap_cnt;
    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [31:0] r_hwdata;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [1:0]  w_idx_inc;
    logic [31:0] w_wdata;
    logic        w_timeout;
    logic        w_unused_ok;

    assign w_idx_inc   = r_idx + 2'd1;
    assign w_unused_ok = &{1'b0, bus.hrdata[31:1], LP_TMO};

    always_comb begin
        w_wdata = 32'h0000_0001;
        case (r_idx)
            2'd0:    w_wdata = r_saddr;
            2'd1:    w_wdata = r_daddr;
            2'd2:    w_wdata = {18'd0, r_number};
            default: w_wdata = 32'h0000_0001;
        endcase
    end

`ifdef DMA_CFG_POLL_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    assign w_timeout = (r_tmo_cnt >= LP_TMO);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state   <= S_IDLE;
            r_idx     <= 2'd0;
            r_saddr   <= 32'd0;
            r_daddr   <= 32'd0;
            r_number  <= 14'd0;
            r_gap_cnt <= 8'd0;
            r_haddr   <= 32'd0;
            r_htrans  <= HTRANS_IDLE;
            r_hwrite  <= 1'b0;
            r_hwdata  <= 32'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
`ifdef DMA_CFG_POLL_TIMEOUT_EN
            r_tmo_cnt <= 16'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_saddr  <= bus.cmd_saddr;
                        r_daddr  <= bus.cmd_daddr;
                        r_number <= bus.cmd_number;
                        r_idx    <= 2'd0;
                        r_haddr  <= BASE_ADDR;
                        r_htrans <= HTRANS_NONSEQ;
                        r_hwrite <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (bus.hready) begin
                        r_htrans <= HTRANS_IDLE;
                        r_hwrite <= 1'b0;
                        r_hwdata <= w_wdata;
                        r_state  <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (bus.hready) begin
                        r_hwdata <= 32'd0;
                        if (bus.hresp) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else if (r_idx != 2'd3) begin
                            r_idx    <= w_idx_inc;
                            r_haddr  <= BASE_ADDR + {28'd0, w_idx_inc, 2'b00};
                            r_htrans <= HTRANS_NONSEQ;
                            r_hwrite <= 1'b1;
                            r_state  <= S_ADDR;
                        end else begin
                            r_haddr  <= START_ADDR;
                            r_htrans <= HTRANS_NONSEQ;
                            r_hwrite <= 1'b0;
                            r_state  <= S_PADDR;
                        end
                    end
                end
                S_PADDR: begin
                    if (bus.hready) begin
                        r_htrans <= HTRANS_IDLE;
                        r_state  <= S_PDATA;
                    end
                end
                S_PDATA: begin
                    if (bus.hready) begin
                        if (bus.hresp) begin
                            r_err   <= 1'b1;
                            r_state <= S_ERR;
                        end else if (bus.hrdata[0]) begin
                            r_gap_cnt <= LP_GAP;
                            r_state   <= S_GAP;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                // Timeout is only honoured here so a poll transfer is never cut short.
                S_GAP: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= S_ERR;
                    end else if (r_gap_cnt <= 8'd1) begin
                        r_haddr  <= START_ADDR;
                        r_htrans <= HTRANS_NONSEQ;
                        r_hwrite <= 1'b0;
                        r_state  <= S_PADDR;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                S_ERR: begin
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
`ifdef DMA_CFG_POLL_TIMEOUT_EN
            if (r_state == S_DATA) begin
                r_tmo_cnt <= 16'd0;
            end else if ((r_state == S_PADDR || r_state == S_PDATA || r_state == S_GAP) &&
                         r_tmo_cnt != 16'hFFFF) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
`endif
        end
    end

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.busy       = r_busy;
    assign bus.done_pulse = r_done;
    assign bus.err_pulse  = r_err;
    assign bus.haddr      = r_haddr;
    assign bus.htrans     = r_htrans;
    assign bus.hwrite     = r_hwrite;
    assign bus.hsize      = 3'b010;
    assign bus.hwdata     = r_hwdata;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_ahb_dma_cfg_master.sv
// Directed bench for ahb_dma_cfg_master: AHB slave responder with stall/error injection,
// transfer log checked against hand-computed expected transfers.
module tb_ahb_dma_cfg_master;
    localparam logic [31:0] B   = 32'h4000_0000;
    localparam int          GAP = 4;

    logic       hclk = 1'b0;
    logic       hreset = 1'b1;
    logic [3:0] dbg_state;

    ahb_dma_cfg_master_if bus();

    ahb_dma_cfg_master #(
        .BASE_ADDR(B), .POLL_GAP(GAP), .TIMEOUT_CYCLES(50)
    ) dut (
        .hclk(hclk), .hreset(hreset), .bus(bus), .o_dbg_state(dbg_state)
    );

    always #5 hclk = ~hclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Responder controls and observations.
    int          wait_n    = 0;
    int          poll_ones = 0;
    logic        err_en    = 1'b0;
    logic [31:0] err_addr  = 32'd0;
    int          done_cnt  = 0;
    int          err_cnt   = 0;
    int          cyc       = 0;
    int          acc_cyc   = 0;
    int          d0        = 0;
    int          e0        = 0;
    logic [64:0] exp_q[$];
    logic [64:0] got_q[$];
    int          t_q[$];

    logic        pending = 1'b0, p_write = 1'b0, hold_chk = 1'b0, h_dphase = 1'b0, h_write = 1'b0;
    logic        in_phase = 1'b0, rd1 = 1'b0;
    logic [31:0] p_addr = 32'd0, h_addr = 32'd0, h_wdata = 32'd0;
    logic [1:0]  h_trans = 2'd0;
    int          wcnt = 0;

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // AHB slave: decides hready/hresp/hrdata each cycle and logs completed transfers.
    initial begin
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = 32'd0;
        forever begin
            @(negedge hclk);
            cyc++;
            if (hreset) begin
                pending = 1'b0; hold_chk = 1'b0; wcnt = 0;
                bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'd0;
                continue;
            end
            if (bus.done_pulse) done_cnt++;
            if (bus.err_pulse) err_cnt++;
            if (bus.cmd_valid && bus.cmd_ready) acc_cyc = cyc;
            if (hold_chk) begin
                if (h_dphase) begin
                    if (h_write) chk("hold_hwdata", bus.hwdata, h_wdata);
                end else begin
                    chk("hold_addr", {bus.htrans, bus.hwrite, bus.haddr}, {h_trans, h_write, h_addr});
                end
            end
            if (!(pending && p_write)) chk("hwdata_zero", bus.hwdata, 32'd0);
            in_phase = pending || (bus.htrans == 2'b10);
            if (in_phase && wcnt < wait_n) begin
                bus.hready = 1'b0;
                wcnt++;
            end else begin
                bus.hready = 1'b1;
                wcnt = 0;
            end
            bus.hresp  = 1'b0;
            bus.hrdata = 32'd0;
            if (in_phase && !bus.hready) begin
                hold_chk = 1'b1;
                h_dphase = pending;
                h_addr   = bus.haddr;
                h_trans  = bus.htrans;
                h_wdata  = bus.hwdata;
                h_write  = pending ? p_write : bus.hwrite;
            end else begin
                hold_chk = 1'b0;
            end
            if (pending && bus.hready) begin
                if (p_write) begin
                    got_q.push_back({1'b1, p_addr, bus.hwdata});
                    if (err_en && p_addr == err_addr) bus.hresp = 1'b1;
                end else begin
                    rd1 = (poll_ones != 0);
                    bus.hrdata = {31'h7FFF_FFFF, rd1};
                    got_q.push_back({1'b0, p_addr, bus.hrdata});
                    if (poll_ones > 0) poll_ones--;
                end
                t_q.push_back(cyc);
                pending = 1'b0;
            end else if (bus.htrans == 2'b10 && bus.hready) begin
                pending = 1'b1;
                p_addr  = bus.haddr;
                p_write = bus.hwrite;
            end
        end
    end

    task automatic start_test();
        exp_q.delete();
        got_q.delete();
        t_q.delete();
        d0 = done_cnt;
        e0 = err_cnt;
    endtask

    task automatic send_cmd(input logic [31:0] s, input logic [31:0] d, input logic [13:0] n);
        bus.cmd_saddr  = s;
        bus.cmd_daddr  = d;
        bus.cmd_number = n;
        bus.cmd_valid  = 1'b1;
        @(posedge hclk); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_saddr  = ~s;
        bus.cmd_daddr  = ~d;
        bus.cmd_number = ~n;
    endtask

    task automatic wait_idle(input string tag, input int max);
        for (int i = 0; i < max; i++) begin
            if (!bus.busy) break;
            @(posedge hclk); #1;
        end
        chk(tag, bus.busy, 1'b0);
    endtask

    task automatic push_writes(input logic [31:0] s, input logic [31:0] d, input logic [13:0] n,
                               input int cnt);
        if (cnt > 0) exp_q.push_back({1'b1, B,          s});
        if (cnt > 1) exp_q.push_back({1'b1, B + 32'h4, d});
        if (cnt > 2) exp_q.push_back({1'b1, B + 32'h8, {18'd0, n}});
        if (cnt > 3) exp_q.push_back({1'b1, B + 32'hC, 32'h1});
    endtask

    task automatic push_polls(input int ones);
        for (int i = 0; i < ones; i++) exp_q.push_back({1'b0, B + 32'hC, 32'hFFFF_FFFF});
        exp_q.push_back({1'b0, B + 32'hC, 32'hFFFF_FFFE});
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s_xfer%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd_saddr  = 32'd0;
        bus.cmd_daddr  = 32'd0;
        bus.cmd_number = 14'd0;
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_htrans", bus.htrans, 2'b00);
        chk("rst_haddr", bus.haddr, 32'd0);
        chk("rst_hwrite", bus.hwrite, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_pulses", {bus.done_pulse, bus.err_pulse}, 2'b00);
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_hsize", bus.hsize, 3'b010);
        hreset = 1'b0;
        @(posedge hclk); #1;

        // 1: basic sequence, first poll reads 0
        start_test();
        poll_ones = 0;
        send_cmd(32'h1000, 32'h2000, 14'h40);
        chk("t1_busy", bus.busy, 1'b1);
        wait_idle("t1_end", 100);
        push_writes(32'h1000, 32'h2000, 14'h40, 4);
        push_polls(0);
        check_log("t1");
        if (t_q.size() == 5) begin
            chk("t1_start_lat", t_q[3] - acc_cyc, 8);
            chk("t1_poll_lat", t_q[4] - t_q[3], 2);
        end
        chk("t1_done", done_cnt - d0, 1);
        chk("t1_err", err_cnt - e0, 0);
        chk("t1_ready", bus.cmd_ready, 1'b1);

        // 2: three busy polls, competing command while busy is ignored
        start_test();
        poll_ones = 3;
        send_cmd(32'hDEAD_BEEC, 32'h0BAD_F00C, 14'h3FFF);
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
            chk("t2_ready_busy", bus.cmd_ready, 1'b0);
        end
        bus.cmd_valid = 1'b0;
        wait_idle("t2_end", 200);
        push_writes(32'hDEAD_BEEC, 32'h0BAD_F00C, 14'h3FFF, 4);
        push_polls(3);
        check_log("t2");
        if (t_q.size() == 8)
            for (int i = 5; i < 8; i++) chk("t2_poll_gap", t_q[i] - t_q[i-1], 2 + GAP);
        chk("t2_done", done_cnt - d0, 1);
        chk("t2_err", err_cnt - e0, 0);

        // 3: three wait states in every phase
        start_test();
        wait_n = 3;
        poll_ones = 1;
        send_cmd(32'h1111_0000, 32'h2222_0000, 14'h0123);
        wait_idle("t3_end", 300);
        wait_n = 0;
        push_writes(32'h1111_0000, 32'h2222_0000, 14'h0123, 4);
        push_polls(1);
        check_log("t3");
        chk("t3_done", done_cnt - d0, 1);

        // 4: error response on the daddr write
        start_test();
        err_en = 1'b1;
        err_addr = B + 32'h4;
        send_cmd(32'hA5A5_0000, 32'h5A5A_0000, 14'h0001);
        wait_idle("t4_end", 100);
        err_en = 1'b0;
        push_writes(32'hA5A5_0000, 32'h5A5A_0000, 14'h0001, 2);
        check_log("t4");
        chk("t4_err", err_cnt - e0, 1);
        chk("t4_done", done_cnt - d0, 0);
        chk("t4_ready", bus.cmd_ready, 1'b1);
        chk("t4_state", dbg_state, 4'd0);

        // 5: reset asserted mid-poll, then a normal command
        start_test();
        poll_ones = 1000;
        send_cmd(32'h0000_3000, 32'h0000_4000, 14'h0010);
        repeat (14) @(posedge hclk);
        #2;
        hreset = 1'b1;
        #1;
        chk("t5_rst_htrans", bus.htrans, 2'b00);
        chk("t5_rst_haddr", bus.haddr, 32'd0);
        chk("t5_rst_hwrite", bus.hwrite, 1'b0);
        chk("t5_rst_hwdata", bus.hwdata, 32'd0);
        chk("t5_rst_busy", bus.busy, 1'b0);
        chk("t5_rst_ready", bus.cmd_ready, 1'b1);
        repeat (2) @(posedge hclk);
        #1;
        hreset = 1'b0;
        poll_ones = 0;
        @(posedge hclk); #1;
        chk("t5_no_pulse", {done_cnt - d0, err_cnt - e0}, 64'd0);
        start_test();
        send_cmd(32'h0000_5000, 32'h0000_6000, 14'h0020);
        wait_idle("t5_end", 100);
        push_writes(32'h0000_5000, 32'h0000_6000, 14'h0020, 4);
        push_polls(0);
        check_log("t5");
        chk("t5_done", done_cnt - d0, 1);

`ifdef DMA_CFG_POLL_TIMEOUT_EN
        // 6: start never clears; timeout after 50 polling cycles gives 9 reads
        start_test();
        poll_ones = -1;
        send_cmd(32'h0000_7000, 32'h0000_8000, 14'h0030);
        wait_idle("t6_end", 300);
        poll_ones = 0;
        chk("t6_err", err_cnt - e0, 1);
        chk("t6_done", done_cnt - d0, 0);
        chk("t6_xfers", got_q.size(), 13);
        for (int i = 0; i < 3; i++) begin
            @(posedge hclk); #1;
            chk("t6_htrans_idle", bus.htrans, 2'b00);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
